// File: rtl/lif_timestep_scheduler.sv
// Time-multiplexed leaky-integrate-and-fire update: one shared datapath sweeps all
// neurons in index order per accepted tick, emitting spikes as valid/ready events.
module lif_timestep_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int THRESHOLD  = 200,
  parameter int REFRACT    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic [N_NEURONS*W-1:0]       isyn,
  output logic                         busy,
  output logic                         done,
  output logic                         spike_valid,
  output logic [$clog2(N_NEURONS)-1:0] spike_id,
  input  logic                         spike_ready,
  output logic [N_NEURONS-1:0]         spike_vec
);

  localparam int IW = $clog2(N_NEURONS);
  localparam int RW = $clog2(REFRACT + 1);
  localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);
  localparam logic [RW-1:0] REFR = RW'(REFRACT);
  localparam logic [W:0]    THR  = (W + 1)'(THRESHOLD);

  typedef enum logic [1:0] {IDLE, UPDATE, EMIT, DONE} state_t;

  state_t               state;
  logic [IW-1:0]        idx;
  logic [W-1:0]         v_mem [N_NEURONS];
  logic [RW-1:0]        r_mem [N_NEURONS];
  logic [N_NEURONS*W-1:0] snap;

  logic [W-1:0]  cur_v;
  logic [W-1:0]  cur_i;
  logic [W-1:0]  leak;
  logic [W-1:0]  vn;
  logic [W:0]    vn_wide;
  logic [RW-1:0] cur_r;
  logic          fire;
  logic          last;

  // V - leak + I cannot exceed 2^(W+1)-1, so one extra bit is enough to detect overflow.
  always_comb begin
    cur_v   = v_mem[idx];
    cur_r   = r_mem[idx];
    cur_i   = snap[int'(idx)*W +: W];
    leak    = cur_v >> LEAK_SHIFT;
    vn_wide = {1'b0, cur_v} - {1'b0, leak} + {1'b0, cur_i};
    vn      = vn_wide[W] ? '1 : vn_wide[W-1:0];
    fire    = (cur_r == '0) && ({1'b0, vn} >= THR);
    last    = (idx == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      spike_valid <= 1'b0;
      spike_id    <= '0;
      spike_vec   <= '0;
      snap        <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem[i] <= '0;
        r_mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            snap      <= isyn;
            spike_vec <= '0;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= UPDATE;
          end
        end
        UPDATE: begin
          if (cur_r != '0) begin
            v_mem[idx] <= '0;
            r_mem[idx] <= cur_r - RW'(1);
          end else if (fire) begin
            v_mem[idx]     <= '0;
            r_mem[idx]     <= REFR;
            spike_vec[idx] <= 1'b1;
            spike_valid    <= 1'b1;
            spike_id       <= idx;
          end else begin
            v_mem[idx] <= vn;
          end
          // A spiking neuron parks the sweep in EMIT; otherwise move on immediately.
          if (cur_r == '0 && fire) begin
            state <= EMIT;
          end else if (last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        EMIT: begin
          if (spike_ready) begin
            spike_valid <= 1'b0;
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx   <= idx + IW'(1);
              state <= UPDATE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
